// File: rtl/pwm_bank_multich.sv
// Multichannel PWM bank: shared prescaler and 8-bit period counter, per-channel
// double-buffered duty, polarity/enable control and a byte-wide register port.
module pwm_bank_multich #(
    parameter int NUM_CH = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [7:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    localparam logic [7:0] A_EN_OUT = 8'h00;
    localparam logic [7:0] A_EN_PWM = 8'h04;
    localparam logic [7:0] A_POL    = 8'h08;
    localparam logic [7:0] A_PRE_LO = 8'h0C;
    localparam logic [7:0] A_PRE_HI = 8'h0D;
    localparam logic [7:0] A_DUTY   = 8'h20;
    localparam logic [7:0] CNT_LAST = 8'd254;

    logic [NUM_CH-1:0] r_en_out;
    logic [NUM_CH-1:0] r_en_pwm;
    logic [NUM_CH-1:0] r_pol;
    logic [DIV_W-1:0]  r_prescale;
    logic [7:0]        r_duty    [NUM_CH];
    logic [7:0]        r_duty_sh [NUM_CH];

    logic [DIV_W-1:0]  r_pcnt;
    logic [7:0]        r_cnt;
    logic              r_loaded;
    logic              r_cnt0_prev;

    logic [NUM_CH-1:0] r_out_p1;
    logic              r_pstart_p1;

    logic              w_wr_presc;
    logic              w_tick;
    logic              w_load;
    logic [NUM_CH-1:0] w_pwm_p0;
    logic [NUM_CH-1:0] w_out_p0;
    logic [7:0]        w_rd;

    // 0xFF is a full-on duty; otherwise high while the counter is below duty.
    function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
        return (duty == 8'hFF) || (cnt < duty);
    endfunction

    assign w_wr_presc = wr_en && ((wr_addr == A_PRE_LO) || ((DIV_W > 8) && (wr_addr == A_PRE_HI)));
    assign w_tick     = (r_pcnt == r_prescale);
    assign w_load     = w_tick && ((r_cnt == CNT_LAST) || !r_loaded);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_out   <= '0;
            r_en_pwm   <= '0;
            r_pol      <= '0;
            r_prescale <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_duty[ch] <= '0;
            end
        end else if (wr_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (wr_addr == A_EN_OUT + 8'(ch / 8)) r_en_out[ch] <= wr_data[ch % 8];
                if (wr_addr == A_EN_PWM + 8'(ch / 8)) r_en_pwm[ch] <= wr_data[ch % 8];
                if (wr_addr == A_POL + 8'(ch / 8))    r_pol[ch]    <= wr_data[ch % 8];
                if (wr_addr == A_DUTY + 8'(ch))       r_duty[ch]   <= wr_data;
            end
            for (int b = 0; b < DIV_W; b++) begin
                if (wr_addr == ((b < 8) ? A_PRE_LO : A_PRE_HI)) r_prescale[b] <= wr_data[b % 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt   <= '0;
            r_cnt    <= '0;
            r_loaded <= 1'b0;
        end else begin
            if (w_wr_presc || w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + DIV_W'(1);
            end
            if (w_tick) begin
                r_cnt    <= (r_cnt == CNT_LAST) ? 8'd0 : r_cnt + 8'd1;
                r_loaded <= 1'b1;
            end
        end
    end

    // Shadow load reads the pre-edge duty, so a write on the wrap edge lands a period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_duty_sh[ch] <= '0;
            end
        end else if (w_load) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_duty_sh[ch] <= r_duty[ch];
            end
        end
    end

    // Stage p0: per-channel level from the current counter and shadow duty
    always_comb begin
        w_pwm_p0 = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_pwm_p0[ch] = pwm_level(r_cnt, r_duty_sh[ch]);
        end
    end

    assign w_out_p0 = r_en_out & (r_pol ^ (w_pwm_p0 | ~r_en_pwm));

    // Stage p1: registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_p1    <= '0;
            r_pstart_p1 <= 1'b0;
            r_cnt0_prev <= 1'b0;
        end else begin
            r_out_p1    <= w_out_p0;
            r_pstart_p1 <= (r_cnt == 8'd0) && !r_cnt0_prev;
            r_cnt0_prev <= (r_cnt == 8'd0);
        end
    end

    assign out          = r_out_p1;
    assign period_start = r_pstart_p1;

    always_comb begin
        w_rd = 8'h00;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rd_addr == A_EN_OUT + 8'(ch / 8)) w_rd[ch % 8] = r_en_out[ch];
            if (rd_addr == A_EN_PWM + 8'(ch / 8)) w_rd[ch % 8] = r_en_pwm[ch];
            if (rd_addr == A_POL + 8'(ch / 8))    w_rd[ch % 8] = r_pol[ch];
            if (rd_addr == A_DUTY + 8'(ch))       w_rd         = r_duty[ch];
        end
        for (int b = 0; b < DIV_W; b++) begin
            if (rd_addr == ((b < 8) ? A_PRE_LO : A_PRE_HI)) w_rd[b % 8] = r_prescale[b];
        end
    end

    assign rd_data = w_rd;

endmodule

// File: tb/tb_pwm_bank_multich.sv
// Bench for pwm_bank_multich: a 16-channel and a 5-channel instance share one
// register bus and are compared every clock against a behavioural model.
module tb_pwm_bank_multich;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [7:0]  wr_addr = 8'h00;
    logic [7:0]  wr_data = 8'h00;
    logic [7:0]  rd_addr = 8'h00;
    logic [7:0]  rd_data, rd_data5;
    logic [15:0] out;
    logic [4:0]  out5;
    logic        ps, ps5;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_bank_multich u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .out(out), .period_start(ps)
    );

    pwm_bank_multich #(.NUM_CH(5), .DIV_W(10)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data5), .out(out5), .period_start(ps5)
    );

    // Reference model: register contents, tick/period position and shadow duties.
    logic [15:0] m_en_out, m_en_pwm, m_pol;
    int          m_presc, m_pcnt, m_cnt, m_last_cnt;
    bit          m_loaded;
    int          m_duty [16];
    int          m_dsh  [16];
    logic [15:0] m_out;
    logic        m_ps;

    logic [7:0]  addrs [16];
    logic [7:0]  ra, rdv;
    int          hi, span;

    function automatic void model_reset();
        m_en_out = '0; m_en_pwm = '0; m_pol = '0;
        m_presc = 0; m_pcnt = 0; m_cnt = 0; m_last_cnt = -1; m_loaded = 0;
        for (int i = 0; i < 16; i++) begin
            m_duty[i] = 0;
            m_dsh[i]  = 0;
        end
        m_out = '0;
        m_ps  = 1'b0;
    endfunction

    function automatic void model_edge(input bit we, input logic [7:0] a, input logic [7:0] d);
        bit level;
        bit tick;
        int ai;
        for (int c = 0; c < 16; c++) begin
            level = (m_dsh[c] == 255) || (m_cnt < m_dsh[c]);
            if (!m_en_pwm[c]) level = 1'b1;
            m_out[c] = m_en_out[c] & (m_pol[c] ^ level);
        end
        m_ps       = (m_cnt == 0) && (m_last_cnt != 0);
        m_last_cnt = m_cnt;
        tick = (m_pcnt == m_presc);
        if (tick) begin
            if (m_cnt == 254 || !m_loaded) begin
                for (int c = 0; c < 16; c++) m_dsh[c] = m_duty[c];
            end
            m_loaded = 1;
            m_cnt = (m_cnt + 1) % 255;
        end
        m_pcnt = tick ? 0 : m_pcnt + 1;
        if (we) begin
            ai = a;
            if (ai == 12 || ai == 13) m_pcnt = 0;
            if (ai < 2)                    m_en_out[8*ai +: 8] = d;
            else if (ai >= 4 && ai < 6)    m_en_pwm[8*(ai-4) +: 8] = d;
            else if (ai >= 8 && ai < 10)   m_pol[8*(ai-8) +: 8] = d;
            else if (ai == 12)             m_presc = (m_presc & 32'hFF00) | int'(d);
            else if (ai == 13)             m_presc = (m_presc & 32'h00FF) | (int'(d) << 8);
            else if (ai >= 32 && ai < 48)  m_duty[ai-32] = d;
        end
    endfunction

    function automatic logic [7:0] exp_rd(input logic [7:0] a, input int nch, input int divw);
        int ai, nb, p;
        logic [31:0] chm, v;
        ai  = a;
        nb  = (nch + 7) / 8;
        chm = (32'd1 << nch) - 32'd1;
        p   = m_presc & ((1 << divw) - 1);
        if (ai < nb)                          v = (32'(m_en_out) & chm) >> (8*ai);
        else if (ai >= 4 && ai < 4 + nb)      v = (32'(m_en_pwm) & chm) >> (8*(ai-4));
        else if (ai >= 8 && ai < 8 + nb)      v = (32'(m_pol) & chm) >> (8*(ai-8));
        else if (ai == 12)                    v = 32'(p);
        else if (ai == 13 && divw > 8)        v = 32'(p >> 8);
        else if (ai >= 32 && ai < 32 + nch)   v = 32'(m_duty[ai-32]);
        else                                  v = 32'd0;
        return v[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(wr_en, wr_addr, wr_data);
        #1;
        chk("out", 32'(out), 32'(m_out));
        chk("period_start", 32'(ps), 32'(m_ps));
        chk("rd_data", 32'(rd_data), 32'(exp_rd(rd_addr, 16, 16)));
        chk("out5", 32'(out5), 32'(m_out[4:0]));
        chk("period_start5", 32'(ps5), 32'(m_ps));
        chk("rd_data5", 32'(rd_data5), 32'(exp_rd(rd_addr, 5, 10)));
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d; rd_addr = a;
        do_cycle();
        wr_en = 1'b0;
    endtask

    task automatic rd_const(input string tag, input logic [7:0] a, input logic [7:0] e16, input logic [7:0] e5);
        rd_addr = a;
        #1;
        chk({tag, "_16"}, 32'(rd_data), 32'(e16));
        chk({tag, "_5"}, 32'(rd_data5), 32'(e5));
    endtask

    // Measures out[0] high count and length of one full period (period_start to period_start).
    task automatic period(input int mid_at, input logic [7:0] ma, input logic [7:0] md,
                          input bit check, input int exp_hi, input int exp_span, input string tag);
        int guard;
        guard = 0;
        hi = 0;
        span = 0;
        while (ps !== 1'b1 && guard < 3000) begin
            do_cycle();
            guard++;
        end
        chk({tag, "_start_timeout"}, 32'(ps), 32'd1);
        if (ps === 1'b1) begin
            do begin
                if (out[0] === 1'b1) hi++;
                if (span == mid_at) begin
                    wr_en = 1'b1; wr_addr = ma; wr_data = md;
                end
                span++;
                do_cycle();
                wr_en = 1'b0;
            end while (ps !== 1'b1 && span < 3000);
            if (check) begin
                chk({tag, "_high"}, 32'(hi), 32'(exp_hi));
                chk({tag, "_period"}, 32'(span), 32'(exp_span));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        addrs = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h08, 8'h09, 8'h0C,
                  8'h0D, 8'h0E, 8'h20, 8'h24, 8'h25, 8'h2F, 8'h30, 8'hFF};
        model_reset();

        // Reset state
        rst_n = 1'b0;
        repeat (3) do_cycle();
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_ps", 32'(ps), 32'd0);
        rd_const("rst_rd00", 8'h00, 8'h00, 8'h00);
        rd_const("rst_rd0c", 8'h0C, 8'h00, 8'h00);
        rd_const("rst_rd20", 8'h20, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Static output enable, one clock latency
        wr(8'h00, 8'h01);
        chk("en_out_write_edge", 32'(out), 32'd0);
        do_cycle();
        chk("en_out_next_clk", 32'(out), 32'h0001);
        chk("en_out_next_clk5", 32'(out5), 32'h01);

        // PWM at prescale 0
        wr(8'h04, 8'h01);
        wr(8'h20, 8'h80);
        wr(8'h0C, 8'h00);
        period(-1, 8'h00, 8'h00, 1'b0, 0, 0, "settle80");
        period(-1, 8'h00, 8'h00, 1'b1, 128, 255, "duty80");

        wr(8'h20, 8'h00);
        period(-1, 8'h00, 8'h00, 1'b0, 0, 0, "settle00");
        period(-1, 8'h00, 8'h00, 1'b1, 0, 255, "duty00");

        wr(8'h20, 8'hFF);
        period(-1, 8'h00, 8'h00, 1'b0, 0, 0, "settleff");
        period(-1, 8'h00, 8'h00, 1'b1, 255, 255, "dutyff");

        wr(8'h08, 8'h01);
        wr(8'h20, 8'h40);
        period(-1, 8'h00, 8'h00, 1'b0, 0, 0, "settlepol");
        period(-1, 8'h00, 8'h00, 1'b1, 191, 255, "pol_duty40");

        // Prescale 3 and a duty write in the middle of a period
        wr(8'h08, 8'h00);
        wr(8'h20, 8'h80);
        wr(8'h0C, 8'h03);
        period(-1, 8'h00, 8'h00, 1'b0, 0, 0, "settlep3");
        period(-1, 8'h00, 8'h00, 1'b1, 512, 1020, "presc3");
        period(300, 8'h20, 8'h10, 1'b1, 512, 1020, "mid_write_hold");
        period(-1, 8'h00, 8'h00, 1'b1, 64, 1020, "mid_write_next");

        // Channel masking and unmapped addresses
        wr(8'h0C, 8'h00);
        wr(8'h00, 8'hFF);
        rd_const("en_out_mask", 8'h00, 8'hFF, 8'h1F);
        wr(8'h25, 8'h77);
        rd_const("duty5_unmapped", 8'h25, 8'h77, 8'h00);
        wr(8'h01, 8'hAA);
        rd_const("byte1_unmapped", 8'h01, 8'hAA, 8'h00);
        wr(8'h0D, 8'hFF);
        rd_const("presc_hi_mask", 8'h0D, 8'hFF, 8'h03);
        rd_const("unmapped_0e", 8'h0E, 8'h00, 8'h00);
        do_cycle();
        chk("pre_reset_nonzero", (out != 16'h0) ? 32'd1 : 32'd0, 32'd1);

        // Asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_out", 32'(out), 32'd0);
        chk("async_rst_out5", 32'(out5), 32'd0);
        chk("async_rst_ps", 32'(ps), 32'd0);
        rd_const("async_rst_rd00", 8'h00, 8'h00, 8'h00);
        repeat (2) do_cycle();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized register traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rd_addr = ($urandom_range(0, 3) == 0) ? 8'h20 + 8'($urandom_range(0, 17))
                                                  : addrs[$urandom_range(0, 15)];
            if ($urandom_range(0, 5) == 0) begin
                ra  = ($urandom_range(0, 2) == 0) ? 8'h20 + 8'($urandom_range(0, 17))
                                                  : addrs[$urandom_range(0, 15)];
                rdv = 8'($urandom_range(0, 255));
                if (ra == 8'h0C) rdv = 8'($urandom_range(0, 3));
                if (ra == 8'h0D) rdv = 8'h00;
                wr_en = 1'b1; wr_addr = ra; wr_data = rdv;
            end
            do_cycle();
            wr_en = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
